// File: rtl/dds_spi_dac_tx.sv
// Serialises one waveform sample per handshake into a 16-bit MCP4921-style SPI write frame (SPI mode 0).
// Define DDS_DAC_LDAC_EN to add an LDAC strobe phase after cs_n rises; otherwise dac_ldac_n is held low.
module dds_spi_dac_tx #(
    parameter int         WAVE_W    = 12,
    parameter int         CLK_DIV   = 2,
    parameter logic [3:0] CFG       = 4'b0111,
    parameter bit         SIGNED_IN = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WAVE_W-1:0] sample_in,
    input  logic              sample_valid,
    output logic              sample_ready,
    output logic              busy,
    output logic              frame_done,
    output logic              spi_sclk,
    output logic              spi_cs_n,
    output logic              spi_mosi,
    output logic              dac_ldac_n
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT_HI,
        SHIFT_LO,
        HOLD,
        GAP,
`ifdef DDS_DAC_LDAC_EN
        LDAC,
`endif
        DONE
    } state_t;

    state_t      state;
    logic [7:0]  cnt;
    logic [3:0]  bit_cnt;
    logic [14:0] shreg;
    logic        phase_end;

    logic [WAVE_W-1:0] samp_c;
    logic [11:0]       data12;

    always_comb begin
        samp_c = sample_in;
        if (SIGNED_IN) samp_c[WAVE_W-1] = ~sample_in[WAVE_W-1];
    end

    // MSB-align to the 12 DAC bits: drop LSBs of wide samples, zero-pad narrow ones.
    generate
        if (WAVE_W >= 12) begin : g_trunc
            assign data12 = samp_c[WAVE_W-1 -: 12];
        end else begin : g_pad
            assign data12 = {samp_c, {(12-WAVE_W){1'b0}}};
        end
    endgenerate

    assign phase_end = (cnt == 8'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            bit_cnt      <= '0;
            shreg        <= '0;
            sample_ready <= 1'b0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            spi_sclk     <= 1'b0;
            spi_cs_n     <= 1'b1;
            spi_mosi     <= 1'b0;
            dac_ldac_n   <= 1'b1;
        end else begin
            frame_done <= 1'b0;
`ifdef DDS_DAC_LDAC_EN
`else
            dac_ldac_n <= 1'b0;
`endif
            cnt <= (state == IDLE || phase_end) ? '0 : cnt + 8'd1;
            case (state)
                IDLE: begin
                    sample_ready <= 1'b1;
                    if (sample_valid && sample_ready) begin
                        // Bit 15 goes straight to mosi; shreg holds the 15 bits still to send.
                        shreg        <= {CFG[2:0], data12};
                        spi_mosi     <= CFG[3];
                        spi_cs_n     <= 1'b0;
                        sample_ready <= 1'b0;
                        busy         <= 1'b1;
                        bit_cnt      <= '0;
                        state        <= SETUP;
                    end
                end
                SETUP: if (phase_end) begin
                    spi_sclk <= 1'b1;
                    state    <= SHIFT_HI;
                end
                SHIFT_HI: if (phase_end) begin
                    spi_sclk <= 1'b0;
                    if (bit_cnt == 4'd15) begin
                        state <= HOLD;
                    end else begin
                        spi_mosi <= shreg[14];
                        shreg    <= {shreg[13:0], 1'b0};
                        bit_cnt  <= bit_cnt + 4'd1;
                        state    <= SHIFT_LO;
                    end
                end
                SHIFT_LO: if (phase_end) begin
                    spi_sclk <= 1'b1;
                    state    <= SHIFT_HI;
                end
                HOLD: if (phase_end) begin
                    spi_cs_n <= 1'b1;
                    state    <= GAP;
                end
                GAP: if (phase_end) begin
`ifdef DDS_DAC_LDAC_EN
                    dac_ldac_n <= 1'b0;
                    state      <= LDAC;
`else
                    frame_done <= 1'b1;
                    state      <= DONE;
`endif
                end
`ifdef DDS_DAC_LDAC_EN
                LDAC: if (phase_end) begin
                    dac_ldac_n <= 1'b1;
                    frame_done <= 1'b1;
                    state      <= DONE;
                end
`endif
                DONE: begin
                    busy         <= 1'b0;
                    sample_ready <= 1'b1;
                    spi_mosi     <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dds_spi_dac_tx.sv
// Directed bench: three DUT builds (default, signed input, CLK_DIV=1 with 14-bit samples) on one clock.
module tb_dds_spi_dac_tx;

`ifdef DDS_DAC_LDAC_EN
    localparam int   LD        = 1;
    localparam logic LDAC_IDLE = 1'b1;
`else
    localparam int   LD        = 0;
    localparam logic LDAC_IDLE = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    logic [11:0] a_in;  logic a_valid, a_ready, a_busy, a_done, a_sclk, a_cs_n, a_mosi, a_ldac_n;
    logic [11:0] s_in;  logic s_valid, s_ready, s_busy, s_done, s_sclk, s_cs_n, s_mosi, s_ldac_n;
    logic [13:0] d_in;  logic d_valid, d_ready, d_busy, d_done, d_sclk, d_cs_n, d_mosi, d_ldac_n;

    dds_spi_dac_tx u_a (
        .clk(clk), .rst(rst), .sample_in(a_in), .sample_valid(a_valid), .sample_ready(a_ready),
        .busy(a_busy), .frame_done(a_done), .spi_sclk(a_sclk), .spi_cs_n(a_cs_n),
        .spi_mosi(a_mosi), .dac_ldac_n(a_ldac_n));

    dds_spi_dac_tx #(.SIGNED_IN(1'b1)) u_s (
        .clk(clk), .rst(rst), .sample_in(s_in), .sample_valid(s_valid), .sample_ready(s_ready),
        .busy(s_busy), .frame_done(s_done), .spi_sclk(s_sclk), .spi_cs_n(s_cs_n),
        .spi_mosi(s_mosi), .dac_ldac_n(s_ldac_n));

    dds_spi_dac_tx #(.WAVE_W(14), .CLK_DIV(1)) u_d (
        .clk(clk), .rst(rst), .sample_in(d_in), .sample_valid(d_valid), .sample_ready(d_ready),
        .busy(d_busy), .frame_done(d_done), .spi_sclk(d_sclk), .spi_cs_n(d_cs_n),
        .spi_mosi(d_mosi), .dac_ldac_n(d_ldac_n));

    // Bus monitors: capture mosi on each sclk rise, count cs_n-low cycles and frame_done pulses.
    logic [15:0] cap[3];
    int          rises[3], csl[3], dcnt[3], viol[3], per[3], lastr[3];
    logic        psclk[3], pmosi[3];

    task automatic mon(input int k, input logic sclk, input logic mosi, input logic cs_n, input logic done);
        if (sclk && !psclk[k]) begin
            cap[k]   = {cap[k][14:0], mosi};
            rises[k] = rises[k] + 1;
            per[k]   = cyc - lastr[k];
            lastr[k] = cyc;
        end
        if (sclk && psclk[k] && mosi !== pmosi[k]) viol[k] = viol[k] + 1;
        if (!cs_n) csl[k] = csl[k] + 1;
        if (done) dcnt[k] = dcnt[k] + 1;
        psclk[k] = sclk;
        pmosi[k] = mosi;
    endtask

    always @(negedge clk) begin
        mon(0, a_sclk, a_mosi, a_cs_n, a_done);
        mon(1, s_sclk, s_mosi, s_cs_n, s_done);
        mon(2, d_sclk, d_mosi, d_cs_n, d_done);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        assert (got === exp) else begin
            failures = failures + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic rdy(input int k);
        case (k)
            0:       return a_ready;
            1:       return s_ready;
            default: return d_ready;
        endcase
    endfunction

    function automatic logic dn(input int k);
        case (k)
            0:       return a_done;
            1:       return s_done;
            default: return d_done;
        endcase
    endfunction

    task automatic drive(input int k, input logic v, input logic [13:0] d);
        case (k)
            0:       begin a_valid = v; a_in = d[11:0]; end
            1:       begin s_valid = v; s_in = d[11:0]; end
            default: begin d_valid = v; d_in = d;       end
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends one sample; len counts clocks from the accept cycle to the frame_done cycle inclusive.
    task automatic send(input int k, input logic [13:0] d, output int len);
        int n;
        n = 0;
        while (!rdy(k) && n < 200) begin tick(); n++; end
        chk("ready_before_send", 32'(rdy(k)), 32'd1);
        rises[k] = 0; csl[k] = 0; viol[k] = 0;
        drive(k, 1'b1, d);
        tick();
        drive(k, 1'b0, d);
        n = 2;
        while (!dn(k) && n < 300) begin tick(); n++; end
        len = n;
    endtask

    initial begin
        int len, n, nacc, ndone, done_cyc, d0;
        for (int i = 0; i < 3; i++) begin
            cap[i] = '0; rises[i] = 0; csl[i] = 0; dcnt[i] = 0; viol[i] = 0;
            per[i] = 0; lastr[i] = 0; psclk[i] = 1'b0; pmosi[i] = 1'b0;
        end
        a_valid = 0; a_in = '0; s_valid = 0; s_in = '0; d_valid = 0; d_in = '0;
        rst = 1'b1;
        repeat (3) tick();

        chk("rst_ready", 32'(a_ready), 32'd0);
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_done", 32'(a_done), 32'd0);
        chk("rst_sclk", 32'(a_sclk), 32'd0);
        chk("rst_cs_n", 32'(a_cs_n), 32'd1);
        chk("rst_mosi", 32'(a_mosi), 32'd0);
        chk("rst_ldac_n", 32'(a_ldac_n), 32'd1);

        rst = 1'b0;
        chk("ready_1st_cycle", 32'(a_ready), 32'd0);
        tick();
        chk("ready_2nd_cycle", 32'(a_ready), 32'd1);
        rises[0] = 0; csl[0] = 0;
        repeat (10) tick();
        chk("idle_rises", 32'(rises[0]), 32'd0);
        chk("idle_cs_low", 32'(csl[0]), 32'd0);
        chk("idle_busy", 32'(a_busy), 32'd0);
        chk("idle_ldac_n", 32'(a_ldac_n), 32'(LDAC_IDLE));

        // Basic frame: 12'hA5C behind CFG 4'b0111.
        send(0, 14'h0A5C, len);
        chk("a5c_data", 32'(cap[0]), 32'h7A5C);
        chk("a5c_rises", 32'(rises[0]), 32'd16);
        chk("a5c_cs_low", 32'(csl[0]), 32'd66);
        chk("a5c_len", 32'(len), 32'(70 + 2 * LD));
        chk("a5c_mosi_stable", 32'(viol[0]), 32'd0);

        // Two's-complement input converted to offset binary.
        send(1, 14'h0800, len);
        chk("signed_800", 32'(cap[1]), 32'h7000);
        send(1, 14'h07FF, len);
        chk("signed_7ff", 32'(cap[1]), 32'h7FFF);

        // Back-to-back with sample_valid held high.
        a_valid = 1'b1; a_in = 12'h001; nacc = 0; ndone = 0; done_cyc = 0;
        for (int i = 0; i < 400 && ndone < 3; i++) begin
            if (a_ready && a_valid) begin
                if (nacc > 0) chk("b2b_accept_gap", 32'(cyc - done_cyc), 32'd1);
                nacc++;
            end
            tick();
            a_in = 12'(nacc + 1);
            if (a_done) begin
                chk("b2b_data", 32'(cap[0]), 32'(16'h7000 | (ndone + 1)));
                ndone++;
                done_cyc = cyc;
                if (ndone == 3) a_valid = 1'b0;
            end
        end
        chk("b2b_frames", 32'(ndone), 32'd3);

        // Reset during the 7th SHIFT_HI phase abandons the frame.
        n = 0;
        while (!a_ready && n < 50) begin tick(); n++; end
        a_in = 12'h3C3; a_valid = 1'b1; rises[0] = 0;
        tick();
        a_valid = 1'b0;
        n = 0;
        while (rises[0] < 7 && n < 200) begin tick(); n++; end
        chk("mid_rises", 32'(rises[0]), 32'd7);
        chk("mid_sclk_high", 32'(a_sclk), 32'd1);
        chk("mid_busy", 32'(a_busy), 32'd1);
        d0 = dcnt[0];
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_cs_n", 32'(a_cs_n), 32'd1);
        chk("mid_rst_sclk", 32'(a_sclk), 32'd0);
        chk("mid_rst_ldac_n", 32'(a_ldac_n), 32'd1);
        chk("mid_rst_busy", 32'(a_busy), 32'd0);
        repeat (100) tick();
        chk("mid_no_done", 32'(dcnt[0]), 32'(d0));
        send(0, 14'h0123, len);
        chk("after_rst_data", 32'(cap[0]), 32'h7123);
        chk("after_rst_rises", 32'(rises[0]), 32'd16);

        // CLK_DIV=1 with a 14-bit sample truncated to 12 bits.
        send(2, 14'h3FFF, len);
        chk("div1_data", 32'(cap[2]), 32'h7FFF);
        chk("div1_len", 32'(len), 32'(36 + LD));
        chk("div1_sclk_period", 32'(per[2]), 32'd2);
        chk("div1_cs_low", 32'(csl[2]), 32'd33);
        chk("div1_rises", 32'(rises[2]), 32'd16);
        send(2, 14'h2A5B, len);
        chk("div1_trunc", 32'(cap[2]), 32'h7A96);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
